traffic_lamp_monitor: RTL and testbench
=======================================

# traffic_lamp_monitor

Passive checker on the six-lamp output bus of the two-way traffic light controller. It decodes the lamp pattern and follows the phase sequence. It checks per-phase dwell time, measured in `tick` pulses, and latches the first protocol violation as a sticky fault. It sits beside the controller in the top level and in the system bench, sharing its `clk`, `rst` and `tick`.

## Interface
- `G_TICKS`, default 5: ticks a green phase (NS_G, EW_G) must be sampled before the change.
- `Y_TICKS`, default 2: ticks a yellow phase (NS_Y, EW_Y) must be sampled before the change.
- `DW`, default 4: dwell counter width; requires 2^DW−1 > G_TICKS and > Y_TICKS.
- `CNT_W`, default 8: cycle counter width.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: timebase strobe, the same one the controller uses.
- `clr` in 1: synchronous fault clear; `rst` has priority.
- `ns_g`, `ns_y`, `ns_r`, `ew_g`, `ew_y`, `ew_r` in 1 each: observed lamps.
- `phase` out 2: last decoded legal phase. NS_G=0, NS_Y=1, EW_G=2, EW_Y=3.
- `tracking` out 1: monitor is locked to the sequence.
- `fault` out 1: sticky violation flag.
- `fault_code` out 3: cause of the first fault. 0 none, 1 illegal pattern, 2 bad sequence, 3 short dwell, 4 long dwell.
- `cycle_cnt` out CNT_W: count of validated full cycles; wraps.

## Operation
- Legal patterns, all six bits, exactly:
  - NS_G = ns_g & ew_r
  - NS_Y = ns_y only
  - EW_G = ew_g & ns_r
  - EW_Y = ew_y only
  - Any other value, including all-off, is illegal.
- Successor order: NS_G→NS_Y→EW_G→EW_Y→NS_G.
- Expected dwell: G_TICKS for NS_G and EW_G, Y_TICKS for NS_Y and EW_Y.
- Dwell definition: the number of posedges with `tick`=1 on which a phase was sampled. The edge that first shows the new phase counts toward that new phase.
- State machine SYNC / TRACK / FAULT. Registers: `phase` (p_prev), dwell counter `dw`.
- Any state except FAULT, illegal pattern: go to FAULT with code 1.
- SYNC:
  - Same phase: no action.
  - Legal successor: go to TRACK, `dw` = tick.
  - Legal non-successor: `phase` updated, stay in SYNC.
  - The partially observed first phase is never dwell-checked.
- TRACK, phase changed:
  - Not the successor: code 2.
  - Successor but `dw` ≠ expected(p_prev): code 3.
  - Otherwise `dw` = tick. If the change is EW_Y→NS_G, `cycle_cnt`+1.
- TRACK, same phase with `tick`=1:
  - `dw` == expected: code 4.
  - Otherwise `dw`+1.
- Check priority on a single edge: 1 > 2 > 3 > 4.
- FAULT: all inputs ignored. `fault`=1, `tracking`=0, code frozen, `phase` frozen, `cycle_cnt` frozen.
- `clr`: go to SYNC, `fault`=0, code=0, `dw`=0. `phase` is reloaded from the current inputs if they are legal. `cycle_cnt` is kept.
- `rst` clears everything, including `cycle_cnt`.

## Timing
- Reset values: `phase`=0, `tracking`=0, `fault`=0, `fault_code`=0, `cycle_cnt`=0, state SYNC, `dw`=0.
- All outputs are registered. A violation sampled at edge k is visible after edge k; latency is 1 clock.
- `tick` can be asserted every cycle. The checks require no idle cycles between ticks.
- A phase change and a tick on the same edge: the change logic applies, and the tick is credited to the new phase.
- `cycle_cnt` wraps from 2^CNT_W−1 to 0 with no flag.
- `rst` asserted mid-phase or mid-fault: the next edge gives the reset values. A restart relocks in SYNC at the first legal successor change.

## Test plan
- Nominal run. Monitor and controller reset together, `tick`=1 every cycle.
  - `tracking`=1 after edge 6.
  - `cycle_cnt`=1 after edge 15, then 3 after edge 43.
  - `fault`=0 throughout.
- Illegal pattern. Drive all lamps 0 for one cycle during TRACK → the next cycle shows `fault`=1 and `fault_code`=1, and they stay so when legal lamps return.
- Skipped yellow. In TRACK, NS_G is held 5 ticks, then EW_G is driven → `fault_code`=2 and `phase`=0 remain.
- Short green. NS_G is held 3 ticks, then NS_Y → `fault_code`=3.
- Stuck yellow. EW_Y is sampled with a 3rd tick → `fault_code`=4, after the edge of that tick.
- Recovery.
  - After any fault, pulse `clr` for 1 cycle with `rst`=0, then resume the nominal sequence → `fault`=0 and `tracking`=1 after the next legal change; `cycle_cnt` keeps its value.
  - Assert `rst` → `cycle_cnt`=0.

Source files
------------

// File: rtl/traffic_lamp_monitor.sv
// rtl/traffic_lamp_monitor.sv - passive phase-sequence and dwell checker for a two-way traffic lamp bus
//
// Ports:
//   clk         single clock, all logic on posedge
//   rst         synchronous active-high reset
//   tick        timebase strobe shared with the traffic controller
//   clr         synchronous fault clear (rst has priority)
//   ns_g/ns_y/ns_r, ew_g/ew_y/ew_r   observed lamps
//   phase       last decoded legal phase: 0 NS_G, 1 NS_Y, 2 EW_G, 3 EW_Y
//   tracking    monitor is locked to the phase sequence
//   fault       sticky violation flag
//   fault_code  cause of first fault: 0 none, 1 illegal, 2 sequence, 3 short dwell, 4 long dwell
//   cycle_cnt   validated full cycles (EW_Y -> NS_G while tracking), wraps silently
module traffic_lamp_monitor #(
    parameter int G_TICKS = 5,
    parameter int Y_TICKS = 2,
    parameter int DW      = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic             ns_g,
    input  logic             ns_y,
    input  logic             ns_r,
    input  logic             ew_g,
    input  logic             ew_y,
    input  logic             ew_r,
    output logic [1:0]       phase,
    output logic             tracking,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_TRACK,
        ST_FAULT
    } state_t;

    localparam logic [1:0] PH_NS_G = 2'd0;
    localparam logic [1:0] PH_NS_Y = 2'd1;
    localparam logic [1:0] PH_EW_G = 2'd2;
    localparam logic [1:0] PH_EW_Y = 2'd3;

    localparam logic [2:0] FC_ILLEGAL = 3'd1;
    localparam logic [2:0] FC_SEQ     = 3'd2;
    localparam logic [2:0] FC_SHORT   = 3'd3;
    localparam logic [2:0] FC_LONG    = 3'd4;

    localparam logic [DW-1:0] G_DW = DW'(G_TICKS);
    localparam logic [DW-1:0] Y_DW = DW'(Y_TICKS);

    state_t        state;
    logic [DW-1:0] dw;

    logic [5:0]    lamps;
    logic          pat_legal;
    logic [1:0]    pat_phase;
    logic [1:0]    succ;
    logic [DW-1:0] exp_dw;
    logic [DW-1:0] dw_start;

    assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};

    // All six bits must match exactly; anything else (including all-off) is illegal.
    always_comb begin
        pat_legal = 1'b1;
        pat_phase = PH_NS_G;
        case (lamps)
            6'b100001: pat_phase = PH_NS_G;
            6'b010000: pat_phase = PH_NS_Y;
            6'b001100: pat_phase = PH_EW_G;
            6'b000010: pat_phase = PH_EW_Y;
            default:   pat_legal = 1'b0;
        endcase
    end

    // Phase encoding puts yellows on odd codes and the successor is simply +1 mod 4.
    assign succ     = phase + 2'd1;
    assign exp_dw   = phase[0] ? Y_DW : G_DW;
    // The edge that first shows a new phase already counts its tick for that phase.
    assign dw_start = {{(DW-1){1'b0}}, tick};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SYNC;
            dw         <= '0;
            phase      <= PH_NS_G;
            tracking   <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            cycle_cnt  <= '0;
        end else if (clr) begin
            state      <= ST_SYNC;
            dw         <= '0;
            tracking   <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            if (pat_legal) begin
                phase <= pat_phase;
            end
        end else if (state != ST_FAULT) begin
            if (!pat_legal) begin
                state      <= ST_FAULT;
                tracking   <= 1'b0;
                fault      <= 1'b1;
                fault_code <= FC_ILLEGAL;
            end else if (state == ST_SYNC) begin
                // The partially seen first phase is never dwell-checked; lock on
                // the first change that follows the legal order.
                if (pat_phase != phase) begin
                    phase <= pat_phase;
                    if (pat_phase == succ) begin
                        state    <= ST_TRACK;
                        tracking <= 1'b1;
                        dw       <= dw_start;
                    end
                end
            end else begin
                if (pat_phase != phase) begin
                    if (pat_phase != succ) begin
                        state      <= ST_FAULT;
                        tracking   <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= FC_SEQ;
                    end else if (dw != exp_dw) begin
                        state      <= ST_FAULT;
                        tracking   <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= FC_SHORT;
                    end else begin
                        phase <= pat_phase;
                        dw    <= dw_start;
                        if (phase == PH_EW_Y) begin
                            cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end
                    end
                end else if (tick) begin
                    // A further tick once the full dwell is reached means the phase overstayed.
                    if (dw == exp_dw) begin
                        state      <= ST_FAULT;
                        tracking   <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= FC_LONG;
                    end else begin
                        dw <= dw + DW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// tb/tb_traffic_lamp_monitor.sv - self-checking bench for traffic_lamp_monitor
module tb_traffic_lamp_monitor;

    localparam int G = 5;
    localparam int Y = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       clr = 1'b0;
    logic       ns_g = 1'b0, ns_y = 1'b0, ns_r = 1'b0;
    logic       ew_g = 1'b0, ew_y = 1'b0, ew_r = 1'b0;
    logic [1:0] phase;
    logic       tracking;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] cycle_cnt;

    traffic_lamp_monitor #(.G_TICKS(G), .Y_TICKS(Y), .DW(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .clr(clr),
        .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
        .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
        .phase(phase), .tracking(tracking), .fault(fault),
        .fault_code(fault_code), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: lock flag, fault flag, current phase, ticks seen in it.
    bit locked, faulted;
    int m_phase, m_ticks, m_code, m_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] lamp_of(input int ph);
        logic [5:0] v;
        case (ph)
            0: v = 6'b100001;
            1: v = 6'b010000;
            2: v = 6'b001100;
            default: v = 6'b000010;
        endcase
        return v;
    endfunction

    function automatic int decode(input logic [5:0] l);
        for (int p = 0; p < 4; p++) begin
            if (l == lamp_of(p)) return p;
        end
        return -1;
    endfunction

    function automatic int need(input int ph);
        return (ph % 2 == 0) ? G : Y;
    endfunction

    task automatic model(input logic [5:0] l, input bit t, input bit c, input bit r);
        int p;
        p = decode(l);
        if (r) begin
            locked = 0; faulted = 0; m_phase = 0; m_ticks = 0; m_code = 0; m_cycles = 0;
        end else if (c) begin
            locked = 0; faulted = 0; m_code = 0; m_ticks = 0;
            if (p >= 0) m_phase = p;
        end else if (!faulted) begin
            if (p < 0) begin
                faulted = 1; locked = 0; m_code = 1;
            end else if (!locked) begin
                if (p != m_phase) begin
                    if (p == (m_phase + 1) % 4) begin
                        locked = 1; m_ticks = t;
                    end
                    m_phase = p;
                end
            end else if (p != m_phase) begin
                if (p != (m_phase + 1) % 4) begin
                    faulted = 1; locked = 0; m_code = 2;
                end else if (m_ticks != need(m_phase)) begin
                    faulted = 1; locked = 0; m_code = 3;
                end else begin
                    if (m_phase == 3) m_cycles = (m_cycles + 1) % 256;
                    m_phase = p; m_ticks = t;
                end
            end else if (t) begin
                if (m_ticks == need(m_phase)) begin
                    faulted = 1; locked = 0; m_code = 4;
                end else begin
                    m_ticks++;
                end
            end
        end
    endtask

    // Drive one cycle, update the model for that edge, sample 1 ns after it.
    task automatic step(input logic [5:0] l, input bit t, input bit c, input bit r);
        {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = l;
        tick = t;
        clr  = c;
        rst  = r;
        @(posedge clk);
        model(l, t, c, r);
        #1;
        check("phase", 32'(phase), 32'(m_phase));
        check("tracking", 32'(tracking), 32'(locked));
        check("fault", 32'(fault), 32'(faulted));
        check("fault_code", 32'(fault_code), 32'(m_code));
        check("cycle_cnt", 32'(cycle_cnt), 32'(m_cycles));
    endtask

    task automatic run_phase(input int ph, input int n);
        for (int i = 0; i < n; i++) step(lamp_of(ph), 1, 0, 0);
    endtask

    function automatic int nominal_phase(input int e);
        int pos;
        pos = (e - 1) % 14;
        if (pos < 5) return 0;
        if (pos < 7) return 1;
        if (pos < 12) return 2;
        return 3;
    endfunction

    initial begin
        int ph, target, nt;
        bit t;
        logic [5:0] l;

        // Reset
        step(lamp_of(0), 1, 0, 1);
        step(lamp_of(0), 1, 0, 1);
        check("rst_phase", 32'(phase), 0);
        check("rst_tracking", 32'(tracking), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_code", 32'(fault_code), 0);
        check("rst_cycles", 32'(cycle_cnt), 0);

        // Nominal run, tick every cycle
        for (int e = 1; e <= 45; e++) begin
            step(lamp_of(nominal_phase(e)), 1, 0, 0);
            if (e == 5)  check("nom_track_e5", 32'(tracking), 0);
            if (e == 6)  check("nom_track_e6", 32'(tracking), 1);
            if (e == 14) check("nom_cyc_e14", 32'(cycle_cnt), 0);
            if (e == 15) check("nom_cyc_e15", 32'(cycle_cnt), 1);
            if (e == 43) check("nom_cyc_e43", 32'(cycle_cnt), 3);
            if (e == 45) check("nom_fault", 32'(fault), 0);
        end

        // Illegal all-off pattern during TRACK
        step(6'b000000, 1, 0, 0);
        check("illegal_fault", 32'(fault), 1);
        check("illegal_code", 32'(fault_code), 1);
        run_phase(0, 2);
        check("illegal_sticky", 32'(fault), 1);
        check("illegal_code_sticky", 32'(fault_code), 1);

        // Recovery with clr, then skipped yellow
        step(lamp_of(0), 1, 1, 0);
        check("clr_fault", 32'(fault), 0);
        check("clr_code", 32'(fault_code), 0);
        check("clr_cycles", 32'(cycle_cnt), 3);
        run_phase(0, 2);
        step(lamp_of(1), 1, 0, 0);
        check("recover_track", 32'(tracking), 1);
        check("recover_cycles", 32'(cycle_cnt), 3);
        run_phase(1, 1);
        run_phase(2, 5);
        run_phase(3, 2);
        run_phase(0, 5);
        check("recover_cyc_inc", 32'(cycle_cnt), 4);
        step(lamp_of(2), 1, 0, 0);
        check("skip_code", 32'(fault_code), 2);
        check("skip_phase", 32'(phase), 0);

        // Short green
        step(lamp_of(0), 1, 1, 0);
        run_phase(0, 1);
        run_phase(1, 2);
        run_phase(2, 5);
        run_phase(3, 2);
        run_phase(0, 3);
        step(lamp_of(1), 1, 0, 0);
        check("short_code", 32'(fault_code), 3);

        // Stuck yellow
        step(lamp_of(0), 1, 1, 0);
        run_phase(0, 1);
        run_phase(1, 2);
        run_phase(2, 5);
        run_phase(3, 2);
        check("stuck_before", 32'(fault), 0);
        step(lamp_of(3), 1, 0, 0);
        check("stuck_fault", 32'(fault), 1);
        check("stuck_code", 32'(fault_code), 4);

        // Reset clears the cycle counter
        step(lamp_of(0), 1, 0, 1);
        check("rst2_cycles", 32'(cycle_cnt), 0);
        check("rst2_fault", 32'(fault), 0);

        // Counter wrap: 257 validated cycles
        run_phase(0, 5);
        for (int k = 0; k < 257; k++) begin
            run_phase(1, 2);
            run_phase(2, 5);
            run_phase(3, 2);
            run_phase(0, 5);
        end
        check("wrap_cycles", 32'(cycle_cnt), 1);

        // Randomized segments against the model
        ph = 0;
        for (int seg = 0; seg < 400; seg++) begin
            if (faulted && $urandom_range(0, 2) == 0) step(lamp_of(ph), 1, 1, 0);
            if ($urandom_range(0, 99) < 85) ph = (ph + 1) % 4;
            else ph = $urandom_range(0, 3);
            target = need(ph);
            if ($urandom_range(0, 99) < 15) target = target - 1 + 2 * $urandom_range(0, 1);
            nt = 0;
            for (int cyc = 0; cyc < 40 && nt < target; cyc++) begin
                t = ($urandom_range(0, 3) != 0);
                l = lamp_of(ph);
                if ($urandom_range(0, 299) == 0) l = 6'($urandom);
                step(l, t, ($urandom_range(0, 499) == 0), ($urandom_range(0, 1999) == 0));
                if (t) nt++;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
